divided_clock_meter: RTL and testbench

Frequency meter for the output of the integer clock divider. Samples the asynchronous divided clock, counts its rising edges over a programmable gate window of `clock_i` cycles, and presents one count per window on a valid/ready port. The port feeds a Xillybus read FIFO, so host software can confirm the programmed `F_DIV` against the measured ratio.

---
 rtl/divided_clock_meter_pkg.sv | 15 +
 rtl/divided_clock_meter_if.sv | 23 ++
 rtl/sync_edge_detect.sv | 26 ++
 rtl/divided_clock_meter.sv | 109 ++++++++++
 tb/tb_divided_clock_meter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/divided_clock_meter_pkg.sv
// Shared types and helpers for the divided-clock frequency meter.
package divided_clock_meter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_t;

  localparam int DROP_WIDTH = 8;

  function automatic logic [DROP_WIDTH-1:0] sat_inc(input logic [DROP_WIDTH-1:0] v);
    return (&v) ? v : v + DROP_WIDTH'(1);
  endfunction

endpackage

// File: rtl/divided_clock_meter_if.sv
// Result port of the meter: one count per window on a valid/ready handshake.
interface divided_clock_meter_if #(
  parameter int COUNT_WIDTH = 32
);
  import divided_clock_meter_pkg::*;

  logic [COUNT_WIDTH-1:0] result_data;
  logic                   result_sat;
  logic                   result_valid;
  logic                   result_ready;
  logic [DROP_WIDTH-1:0]  drop_count;

  modport master (
    output result_data, result_sat, result_valid, drop_count,
    input  result_ready
  );

  modport slave (
    input  result_data, result_sat, result_valid, drop_count,
    output result_ready
  );

endinterface

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous strobe and emits a one-cycle pulse on its rising edge.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock_i,
  input  logic reset_n,
  input  logic strobe,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clock_i or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], strobe};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/divided_clock_meter.sv
// Counts rising edges of the divided clock over a gate window and offers one count per window.
//   state | meaning
//   IDLE  | no window running; waiting for enable with a non-zero gate length
//   GATE  | window open; gate_cnt runs 0..gate_q-1, edges accumulate in edge_cnt
module divided_clock_meter
  import divided_clock_meter_pkg::*;
#(
  parameter int GATE_WIDTH  = 32,
  parameter int COUNT_WIDTH = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock_i,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [GATE_WIDTH-1:0] gate_len,
  input  logic                  meas_clock,
  divided_clock_meter_if.master res
);

  state_t                 state_q, state_d;
  logic [GATE_WIDTH-1:0]  gate_q, gate_cnt;
  logic [COUNT_WIDTH-1:0] edge_cnt, final_cnt, data_q;
  logic                   sat_q, final_sat, rsat_q, valid_q;
  logic [DROP_WIDTH-1:0]  drop_q;
  logic                   edge_pulse, start_ok, gate_end, load_win, accept;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock_i (clock_i),
    .reset_n (reset_n),
    .strobe  (meas_clock),
    .rise    (edge_pulse)
  );

  always_ff @(posedge clock_i or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = GATE;
      GATE:    if (!enable || (gate_end && !start_ok)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_ok = enable && (gate_len != '0);
    gate_end = 1'b0;
    load_win = 1'b0;
    case (state_q)
      IDLE: load_win = start_ok;
      GATE: begin
        gate_end = enable && (gate_cnt == gate_q - GATE_WIDTH'(1));
        load_win = gate_end && start_ok;
      end
      default: ;
    endcase
  end

  // The edge seen in the last gate cycle still belongs to this window.
  assign final_cnt = (edge_pulse && !(&edge_cnt)) ? edge_cnt + COUNT_WIDTH'(1) : edge_cnt;
  assign final_sat = sat_q | (edge_pulse & (&edge_cnt));
  assign accept    = valid_q & res.result_ready;

  always_ff @(posedge clock_i or negedge reset_n) begin
    if (!reset_n) begin
      gate_q   <= '0;
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat_q    <= 1'b0;
    end else if (load_win) begin
      gate_q   <= gate_len;
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat_q    <= 1'b0;
    end else if (state_q == GATE) begin
      gate_cnt <= gate_cnt + GATE_WIDTH'(1);
      edge_cnt <= final_cnt;
      sat_q    <= final_sat;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      rsat_q  <= 1'b0;
      valid_q <= 1'b0;
      drop_q  <= '0;
    end else if (gate_end) begin
      if (!valid_q || res.result_ready) begin
        data_q  <= final_cnt;
        rsat_q  <= final_sat;
        valid_q <= 1'b1;
      end else begin
        drop_q  <= sat_inc(drop_q);
      end
    end else if (accept) begin
      valid_q <= 1'b0;
    end
  end

  assign res.result_data  = data_q;
  assign res.result_sat   = rsat_q;
  assign res.result_valid = valid_q;
  assign res.drop_count   = drop_q;

endmodule

// File: tb/tb_divided_clock_meter.sv
// Directed bench for divided_clock_meter: nominal ratios, backpressure, saturation, abort and reset.
module tb_divided_clock_meter;

  logic        clock_i = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] gate_len = '0;
  logic        meas_main = 1'b0;
  int          half_main = 20;
  logic        en_s = 1'b0;
  logic [31:0] glen_s = '0;
  logic        meas_s = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  divided_clock_meter_if #(.COUNT_WIDTH(32)) main_if ();
  divided_clock_meter_if #(.COUNT_WIDTH(4))  small_if ();

  divided_clock_meter #(.GATE_WIDTH(32), .COUNT_WIDTH(32), .SYNC_STAGES(2)) dut (
    .clock_i (clock_i), .reset_n (reset_n), .enable (enable),
    .gate_len (gate_len), .meas_clock (meas_main), .res (main_if.master)
  );

  divided_clock_meter #(.GATE_WIDTH(32), .COUNT_WIDTH(4), .SYNC_STAGES(2)) dut_small (
    .clock_i (clock_i), .reset_n (reset_n), .enable (en_s),
    .gate_len (glen_s), .meas_clock (meas_s), .res (small_if.master)
  );

  always #5 clock_i = ~clock_i;
  always @(posedge clock_i) cyc++;

  // Divider outputs modelled as free-running async clocks; toggles never coincide with clock_i edges.
  initial begin
    #3;
    forever begin
      meas_main = ~meas_main;
      #(half_main);
    end
  end

  initial begin
    #3;
    forever begin
      meas_s = ~meas_s;
      #10;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input logic [63:0] obs, input logic [63:0] lo,
                           input logic [63:0] hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic get_res(input string tag, input int budget, output logic [31:0] d,
                         output logic s, output int n, output int t);
    n = 0;
    do begin
      @(negedge clock_i);
      n++;
    end while (!main_if.result_valid && n < budget);
    check({tag, "_arrived"}, main_if.result_valid, 1);
    d = main_if.result_data;
    s = main_if.result_sat;
    t = cyc;
  endtask

  logic [31:0] d;
  logic        s;
  int          n, t, t_prev;
  bit          seen;

  initial begin
    main_if.result_ready = 1'b1;
    small_if.result_ready = 1'b1;

    repeat (3) @(negedge clock_i);
    check("rst_valid", main_if.result_valid, 0);
    check("rst_data", main_if.result_data, 0);
    check("rst_sat", main_if.result_sat, 0);
    check("rst_drop", main_if.drop_count, 0);
    @(negedge clock_i);
    reset_n = 1'b1;

    enable = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clock_i);
      if (main_if.result_valid) seen = 1;
    end
    check("zero_gate_idle", seen, 0);

    glen_s = 100;
    en_s = 1'b1;
    n = 0;
    do begin
      @(negedge clock_i);
      n++;
    end while (!small_if.result_valid && n < 300);
    check("sat_arrived", small_if.result_valid, 1);
    check("sat_data", small_if.result_data, 15);
    check("sat_flag", small_if.result_sat, 1);
    en_s = 1'b0;

    gate_len = 1000;
    get_res("f4_first", 1200, d, s, n, t);
    t_prev = t;
    for (int i = 0; i < 3; i++) begin
      get_res("f4", 1200, d, s, n, t);
      check("f4_data", d, 250);
      check("f4_sat", s, 0);
      check("f4_period", t - t_prev, 1000);
      t_prev = t;
    end
    check("f4_drop", main_if.drop_count, 0);

    half_main = 15;
    get_res("f3_settle", 1200, d, s, n, t);
    for (int i = 0; i < 3; i++) begin
      get_res("f3", 1200, d, s, n, t);
      check_rng("f3_data", d, 333, 334);
    end

    half_main = 35;
    gate_len = 700;
    get_res("f7_settle_a", 1200, d, s, n, t);
    get_res("f7_settle_b", 1200, d, s, n, t);
    get_res("f7_a", 1200, d, s, n, t);
    check_rng("f7_range", d, 99, 101);
    get_res("f7_b", 1200, d, s, n, t);
    check("f7_steady", d, 100);
    repeat (2) @(negedge clock_i);

    enable = 1'b0;
    main_if.result_ready = 1'b0;
    half_main = 20;
    gate_len = 100;
    repeat (10) @(negedge clock_i);
    enable = 1'b1;
    get_res("bp_first", 300, d, s, n, t);
    check("bp_first_data", d, 25);
    repeat (250) @(negedge clock_i);
    check("bp_valid_held", main_if.result_valid, 1);
    check("bp_data_frozen", main_if.result_data, 25);
    check("bp_drop", main_if.drop_count, 2);
    enable = 1'b0;
    main_if.result_ready = 1'b1;
    @(negedge clock_i);
    check("bp_accepted", main_if.result_valid, 0);

    repeat (5) @(negedge clock_i);
    enable = 1'b1;
    repeat (50) @(negedge clock_i);
    enable = 1'b0;
    seen = 0;
    repeat (200) begin
      @(negedge clock_i);
      if (main_if.result_valid) seen = 1;
    end
    check("abort_no_result", seen, 0);
    enable = 1'b1;
    get_res("reenable", 300, d, s, n, t);
    check("reenable_latency", n, 101);
    check("reenable_data", d, 25);

    main_if.result_ready = 1'b0;
    repeat (30) @(negedge clock_i);
    check("pre_rst_valid", main_if.result_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", main_if.result_valid, 0);
    check("arst_data", main_if.result_data, 0);
    check("arst_sat", main_if.result_sat, 0);
    check("arst_drop", main_if.drop_count, 0);
    @(negedge clock_i);
    reset_n = 1'b1;
    main_if.result_ready = 1'b1;
    get_res("post_rst", 300, d, s, n, t);
    check("post_rst_latency", n, 101);
    check("post_rst_data", d, 25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
